// File: rtl/router_dest_rx_if.sv
// Byte stream from the router port reader to its downstream consumer.
// The reader drives data and framing flags; the consumer drives m_ready.
interface router_dest_rx_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_sop;
  logic       m_eop;
  logic       m_ready;

  modport master (output m_data, m_valid, m_sop, m_eop, input m_ready);
  modport slave  (input m_data, m_valid, m_sop, m_eop, output m_ready);
endinterface

// File: rtl/router_dest_rx.sv
// Destination-side reader for one router output port.
// Drains header, payload and parity bytes from the port FIFO (read latency 1),
// forwards header and payload through a 2-entry skid buffer onto a byte
// stream, and checks the destination address and the XOR parity.
// Optional build macro ROUTER_RX_WATCHDOG_EN adds a stall watchdog that aborts
// a packet after TIMEOUT cycles without FIFO data; without it timeout_err is 0.
//
// state | meaning
// IDLE  | waiting for a header; header read issues when FIFO and buffer allow
// HDR   | header byte returning: load len/rem/acc, push it with sop
// BODY  | payload reads while rem>0, then the parity read
// PAR   | parity byte returning: pulse pkt_done / parity_err
module router_dest_rx #(
  parameter logic [1:0] PORT_ID = 2'd0,
  parameter int         TIMEOUT = 64
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    vld_out,
  input  logic [7:0]              data_out,
  output logic                    read_enb,
  router_dest_rx_if.master        m,
  output logic                    pkt_done,
  output logic                    parity_err,
  output logic                    addr_err,
  output logic                    timeout_err
);

  typedef enum logic [1:0] {IDLE, HDR, BODY, PAR} state_t;

  state_t     state, state_nx;
  logic [5:0] rem, rem_nx;
  logic [7:0] acc, acc_nx;
  logic       rd_push_q;   // header/payload read issued last cycle, data arrives now
  logic       rd_eop_q;    // that read was the last payload byte
  logic [9:0] buf0, buf1;  // {sop, eop, data}; buf0 is the head
  logic [1:0] occ;
  logic       pop, push;
  logic [9:0] push_ent;
  logic [2:0] used;
  logic       can_read;
  logic       rd_hdr, rd_pay, rd_par;
  logic       done_c, perr_c, aerr_c;
  logic       wd_fire;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("router_dest_rx: TIMEOUT must be at least 1");
  end

  assign pop      = m.m_valid && m.m_ready;
  // slots that will be taken once the in-flight byte lands; a pop this cycle frees one
  assign used     = {1'b0, occ} + {2'b00, rd_push_q} - {2'b00, pop};
  assign can_read = (used < 3'd2);

  assign m.m_valid = (occ != 2'd0);
  assign m.m_data  = m.m_valid ? buf0[7:0] : 8'h00;
  assign m.m_sop   = m.m_valid && buf0[9];
  assign m.m_eop   = m.m_valid && buf0[8];

  assign read_enb   = resetn && (rd_hdr || rd_pay || rd_par);
  assign pkt_done   = resetn && done_c;
  assign parity_err = resetn && perr_c;
  assign addr_err   = resetn && aerr_c;

`ifdef ROUTER_RX_WATCHDOG_EN
  localparam logic [15:0] WD_LOAD = 16'(TIMEOUT - 1);
  logic [15:0] wd_cnt;
  logic        wd_wait;

  assign wd_wait     = (state == BODY) && !vld_out;
  assign wd_fire     = wd_wait && (wd_cnt == 16'd0);
  assign timeout_err = resetn && wd_fire;

  // stall down-counter: reloads whenever the FSM is not starved of FIFO data
  always_ff @(posedge clock) begin
    if (!resetn || !wd_wait)
      wd_cnt <= WD_LOAD;
    else if (wd_cnt != 16'd0)
      wd_cnt <= wd_cnt - 16'd1;
  end
`else
  assign wd_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // next-state, read issue, capture and status pulses
  always_comb begin
    state_nx = state;
    rem_nx   = rem;
    acc_nx   = acc;
    rd_hdr   = 1'b0;
    rd_pay   = 1'b0;
    rd_par   = 1'b0;
    push     = 1'b0;
    push_ent = 10'h000;
    done_c   = 1'b0;
    perr_c   = 1'b0;
    aerr_c   = 1'b0;
    case (state)
      IDLE: begin
        if (vld_out && can_read) begin
          rd_hdr   = 1'b1;
          state_nx = HDR;
        end
      end
      HDR: begin
        rem_nx   = data_out[7:2];
        acc_nx   = data_out;
        push     = 1'b1;
        push_ent = {1'b1, (data_out[7:2] == 6'd0), data_out};
        aerr_c   = (data_out[1:0] != PORT_ID);
        state_nx = BODY;
      end
      BODY: begin
        if (rd_push_q) begin
          acc_nx   = acc ^ data_out;
          push     = 1'b1;
          push_ent = {1'b0, rd_eop_q, data_out};
        end
        if (rem != 6'd0) begin
          if (vld_out && can_read) begin
            rd_pay = 1'b1;
            rem_nx = rem - 6'd1;
          end
        end else if (vld_out) begin
          // parity byte is never buffered, so it needs no credit
          rd_par   = 1'b1;
          state_nx = PAR;
        end
      end
      PAR: begin
        done_c   = 1'b1;
        perr_c   = (data_out != acc);
        state_nx = IDLE;
        if (vld_out && can_read) begin
          rd_hdr   = 1'b1;
          state_nx = HDR;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (wd_fire) begin
      state_nx = IDLE;
      rem_nx   = 6'd0;
      acc_nx   = 8'h00;
      push     = 1'b0;
    end
  end

  // FSM state, packet counters and in-flight read tracking
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= IDLE;
      rem       <= 6'd0;
      acc       <= 8'h00;
      rd_push_q <= 1'b0;
      rd_eop_q  <= 1'b0;
    end else begin
      state     <= state_nx;
      rem       <= rem_nx;
      acc       <= acc_nx;
      rd_push_q <= rd_hdr || rd_pay;
      rd_eop_q  <= rd_pay && (rem == 6'd1);
    end
  end

  // 2-entry skid buffer; the head stays put while the consumer stalls
  always_ff @(posedge clock) begin
    if (!resetn || wd_fire) begin
      occ  <= 2'd0;
      buf0 <= 10'h000;
      buf1 <= 10'h000;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) buf0 <= push_ent;
          else             buf1 <= push_ent;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf0 <= push_ent;
          end else begin
            buf0 <= buf1;
            buf1 <= push_ent;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_router_dest_rx.sv
// Directed bench for router_dest_rx: a queue-based FIFO model answers reads
// with one cycle of latency, a monitor records stream transfers and pulses.
module tb_router_dest_rx;
  logic       clock = 1'b0;
  logic       resetn;
  logic       vld_out;
  logic [7:0] data_out;
  logic       read_enb;
  logic       pkt_done, parity_err, addr_err, timeout_err;

  router_dest_rx_if sif ();

  router_dest_rx #(.PORT_ID(2'd0), .TIMEOUT(16)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .vld_out     (vld_out),
    .data_out    (data_out),
    .read_enb    (read_enb),
    .m           (sif),
    .pkt_done    (pkt_done),
    .parity_err  (parity_err),
    .addr_err    (addr_err),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  logic [7:0] fifo[$];
  logic [9:0] rx[$];
  logic       rd_s = 1'b0;
  int         n_reads, n_done, n_perr, n_aerr, n_terr;
  int         checks = 0;
  int         failures = 0;

  // sample mid-cycle: pending read, stream transfers, status pulses
  always @(negedge clock) begin
    rd_s = read_enb;
    if (sif.m_valid && sif.m_ready) rx.push_back({sif.m_sop, sif.m_eop, sif.m_data});
    if (read_enb) n_reads++;
    if (pkt_done) n_done++;
    if (pkt_done && parity_err) n_perr++;
    if (addr_err) n_aerr++;
    if (timeout_err) n_terr++;
  end

  // FIFO model: data appears the cycle after read_enb, Z otherwise
  always @(posedge clock) begin
    #1;
    if (rd_s && fifo.size() != 0) data_out = fifo.pop_front();
    else                          data_out = 'z;
    rd_s    = 1'b0;
    vld_out = resetn && (fifo.size() != 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic clr();
    rx.delete();
    n_reads = 0; n_done = 0; n_perr = 0; n_aerr = 0; n_terr = 0;
  endtask

  function automatic logic [9:0] rx_at(input int i);
    if (i < rx.size()) return rx[i];
    return 10'h3FF;
  endfunction

  initial begin
    resetn = 1'b0; vld_out = 1'b0; data_out = 'z; sif.m_ready = 1'b1;
    clr();
    cyc(3);
    resetn = 1'b1;
    @(negedge clock);
    chk("rst_read_enb", read_enb, 1'b0);
    chk("rst_m_valid", sif.m_valid, 1'b0);
    chk("rst_m_bus", {sif.m_data, sif.m_sop, sif.m_eop}, 10'h000);
    chk("rst_pulses", {pkt_done, parity_err, addr_err}, 3'b000);
    chk("rst_timeout", timeout_err, 1'b0);

    // len 3, good parity
    cyc(1); clr();
    fifo = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h0C};
    cyc(20);
    chk("t1_count", rx.size(), 4);
    chk("t1_b0", rx_at(0), 10'h20C);
    chk("t1_b1", rx_at(1), 10'h011);
    chk("t1_b2", rx_at(2), 10'h022);
    chk("t1_b3", rx_at(3), 10'h133);
    chk("t1_done", n_done, 1);
    chk("t1_perr", n_perr, 0);
    chk("t1_aerr", n_aerr, 0);
    chk("t1_reads", n_reads, 5);

    // same packet, bad parity byte
    clr();
    fifo = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h00};
    cyc(20);
    chk("t2_done", n_done, 1);
    chk("t2_perr_with_done", n_perr, 1);
    chk("t2_count", rx.size(), 4);

    // len 0, wrong port address
    clr();
    fifo = '{8'h01, 8'h01};
    cyc(12);
    chk("t3_count", rx.size(), 1);
    chk("t3_b0", rx_at(0), 10'h301);
    chk("t3_aerr", n_aerr, 1);
    chk("t3_done", n_done, 1);
    chk("t3_perr", n_perr, 0);

    // len 5 against a stalled consumer
    clr();
    sif.m_ready = 1'b0;
    fifo = '{8'h14, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h15};
    cyc(10);
    @(negedge clock);
    chk("t4_stall_reads", n_reads, 2);
    chk("t4_stall_valid", sif.m_valid, 1'b1);
    chk("t4_stall_head", {sif.m_sop, sif.m_eop, sif.m_data}, 10'h214);
    chk("t4_stall_no_xfer", rx.size(), 0);
    cyc(1);
    sif.m_ready = 1'b1;
    cyc(25);
    chk("t4_count", rx.size(), 6);
    chk("t4_b0", rx_at(0), 10'h214);
    chk("t4_b1", rx_at(1), 10'h001);
    chk("t4_b3", rx_at(3), 10'h003);
    chk("t4_b5", rx_at(5), 10'h105);
    chk("t4_done", n_done, 1);
    chk("t4_perr", n_perr, 0);

    // FIFO runs dry after the 2nd payload byte
    clr();
    fifo = '{8'h10, 8'hA1, 8'hA2};
    cyc(30);
    chk("t5_hold_count", rx.size(), 3);
    chk("t5_hold_done", n_done, 0);
`ifdef ROUTER_RX_WATCHDOG_EN
    chk("t5_timeout", n_terr, 1);
    clr();
    fifo = '{8'h01, 8'h01};
    cyc(12);
    chk("t5_after_abort", rx_at(0), 10'h301);
    chk("t5_after_done", n_done, 1);
`else
    chk("t5_timeout", n_terr, 0);
    fifo = '{8'hA3, 8'hA4, 8'h14};
    cyc(20);
    chk("t5_count", rx.size(), 5);
    chk("t5_b4", rx_at(4), 10'h1A4);
    chk("t5_done", n_done, 1);
    chk("t5_perr", n_perr, 0);
`endif

    // reset in the middle of BODY with bytes buffered
    clr();
    sif.m_ready = 1'b0;
    fifo = '{8'h0C, 8'h11};
    cyc(8);
    @(negedge clock);
    chk("t6_pre_valid", sif.m_valid, 1'b1);
    cyc(1);
    resetn = 1'b0;
    fifo.delete();
    cyc(1);
    resetn = 1'b1;
    @(negedge clock);
    chk("t6_rst_valid", sif.m_valid, 1'b0);
    chk("t6_rst_read", read_enb, 1'b0);
    chk("t6_rst_bus", {sif.m_data, sif.m_sop, sif.m_eop}, 10'h000);
    cyc(1); clr();
    sif.m_ready = 1'b1;
    fifo = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h0C};
    cyc(20);
    chk("t6_count", rx.size(), 4);
    chk("t6_b0", rx_at(0), 10'h20C);
    chk("t6_b3", rx_at(3), 10'h133);
    chk("t6_done", n_done, 1);
    chk("t6_perr", n_perr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
